// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_pkg
//  Description : Shared types, constants and helpers for the clk_rate_gen
//                programmable rate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

    // Default width of divisor, counter and duty values
    localparam int c_default_div_w = 16;

    // Working width of the helper function; wide enough for any DIV_W in use
    localparam int c_fn_w = 32;

    // Generator run state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ceil(d/2) without overflow: floor(d/2) plus the dropped LSB
    function automatic logic [c_fn_w-1:0] half_ceil(input logic [c_fn_w-1:0] d);
        return (d >> 1) + {{(c_fn_w-1){1'b0}}, d[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_period_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_period_ctr
//  Description : Period wrap counter for clk_rate_gen. Counts 0..div-1 while
//                running and restarts from 0 whenever the generator (re)enters
//                RUN. Exposes the count for the upcoming cycle (so the parent
//                can register outputs that line up with it) and the wrap
//                strobe, which is high in the last cycle of a period.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgen_period_ctr
    import clkgen_pkg::*;
#(
    parameter int DIV_W = c_default_div_w
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             active,    // generator is in RUN this cycle
    input  logic             run_next,  // generator will be in RUN next cycle
    input  logic [DIV_W-1:0] div,       // divisor governing the current period
    output logic [DIV_W-1:0] cnt_next,  // count value for the next cycle
    output logic             wrap       // current cycle is cnt == div-1
);

    localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             wrap_w;

    // Wrap strobe and next count: advance inside a period, otherwise restart at 0
    always_comb begin
        wrap_w = active && (cnt_q == (div - c_one));
        cnt_d  = '0;
        if (run_next && active && !wrap_w) begin
            cnt_d = cnt_q + c_one;
        end
    end

    // Count register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next = cnt_d;
    assign wrap     = wrap_w;

endmodule
`default_nettype wire

// File: rtl/clk_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rate_gen
//  Description : Programmable single-clock rate generator. Divides clk_in by
//                a runtime divisor, producing a registered square wave
//                (clk_out) and a first-cycle-of-period strobe (tick). Divisor
//                updates are captured into a pending register and applied
//                only at a period boundary (or immediately when idle), so
//                clk_out never glitches.
//                Optional feature macro: CLKGEN_DUTY_EN adds duty_val, which
//                sets the high-phase length to min(duty_val, D) instead of
//                ceil(D/2).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rate_gen
    import clkgen_pkg::*;
#(
    parameter int DIV_W       = c_default_div_w,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
`ifdef CLKGEN_DUTY_EN
    input  logic [DIV_W-1:0] duty_val,
`endif
    input  logic             div_load,
    output logic             div_ack,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_reset_div = DIV_W'(DEFAULT_DIV);
`ifdef CLKGEN_DUTY_EN
    localparam logic [DIV_W-1:0] c_reset_duty = DIV_W'(half_ceil(c_fn_w'(DEFAULT_DIV)));
`endif

    state_t           state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [DIV_W-1:0] pend_div_q,  pend_div_d;
    logic             pending_q,   pending_d;
    logic             div_ack_q,   div_ack_d;
    logic             clk_out_q,   clk_out_d;
    logic             tick_q,      tick_d;
`ifdef CLKGEN_DUTY_EN
    logic [DIV_W-1:0] duty_q,      duty_d;
    logic [DIV_W-1:0] pend_duty_q, pend_duty_d;
`endif

    logic             w_apply;
    logic             w_wrap;
    logic             w_run_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_high;

    clkgen_period_ctr #(
        .DIV_W    (DIV_W)
    ) u_period_ctr (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .active   (state_q == ST_RUN),
        .run_next (w_run_next),
        .div      (div_q),
        .cnt_next (w_cnt_next),
        .wrap     (w_wrap)
    );

    // Divisor handshake: apply the pending value at a boundary (or at once when
    // idle); a coincident load becomes the new pending value
    always_comb begin
        pending_d  = pending_q;
        pend_div_d = pend_div_q;
        div_d      = div_q;
        div_ack_d  = 1'b0;
`ifdef CLKGEN_DUTY_EN
        pend_duty_d = pend_duty_q;
        duty_d      = duty_q;
`endif
        w_apply = pending_q && ((state_q == ST_IDLE) || w_wrap);
        if (w_apply) begin
            div_d     = pend_div_q;
            div_ack_d = 1'b1;
            pending_d = 1'b0;
`ifdef CLKGEN_DUTY_EN
            duty_d    = pend_duty_q;
`endif
        end
        if (div_load) begin
            pend_div_d = div_val;
            pending_d  = 1'b1;
`ifdef CLKGEN_DUTY_EN
            pend_duty_d = duty_val;
`endif
        end
    end

    // Next run state: run only while enabled with a non-zero divisor
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (en && (div_d != '0)) ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = (!en || (div_d == '0)) ? ST_IDLE : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        w_run_next = (state_d == ST_RUN);
    end

    // Registered outputs, computed against the count of the upcoming cycle
    always_comb begin
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
`ifdef CLKGEN_DUTY_EN
        w_high = (duty_d > div_d) ? div_d : duty_d;
`else
        w_high = DIV_W'(half_ceil(c_fn_w'(div_d)));
`endif
        if (w_run_next) begin
            tick_d    = (w_cnt_next == '0);
            clk_out_d = (w_cnt_next < w_high);
        end
    end

    // State, divisor and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= c_reset_div;
            pend_div_q  <= '0;
            pending_q   <= 1'b0;
            div_ack_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
`ifdef CLKGEN_DUTY_EN
            duty_q      <= c_reset_duty;
            pend_duty_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pend_div_q  <= pend_div_d;
            pending_q   <= pending_d;
            div_ack_q   <= div_ack_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
`ifdef CLKGEN_DUTY_EN
            duty_q      <= duty_d;
            pend_duty_q <= pend_duty_d;
`endif
        end
    end

    assign div_ack = div_ack_q;
    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rate_gen
//  Description : Self-checking bench for clk_rate_gen. A table of per-cycle
//                vectors covers start-up, divisor reloads and double loads;
//                hand-written sequences cover stop-by-zero, D=1, enable drop,
//                asynchronous reset and (with CLKGEN_DUTY_EN) duty control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rate_gen;

    logic        clk_in;
    logic        rst_n;
    logic        en;
    logic [15:0] div_val;
    logic [15:0] duty_val;
    logic        div_load;
    logic        div_ack;
    logic        pending;
    logic        clk_out;
    logic        tick;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        clk;
        logic        tck;
        logic        ack;
        logic        pend;
    } vec_t;

    vec_t vecs[$];

    clk_rate_gen #(
        .DIV_W       (16),
        .DEFAULT_DIV (2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
`ifdef CLKGEN_DUTY_EN
        .duty_val (duty_val),
`endif
        .div_load (div_load),
        .div_ack  (div_ack),
        .pending  (pending),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hc(input logic [15:0] v);
        return (v >> 1) + {15'b0, v[0]};
    endfunction

    // Drive one cycle of inputs, clock it, settle 1 ns past the edge
    task automatic step(input logic e, input logic ld, input logic [15:0] v, input logic [15:0] dty);
        en       = e;
        div_load = ld;
        div_val  = v;
        duty_val = dty;
        @(posedge clk_in);
        #1;
        div_load = 1'b0;
    endtask

    task automatic stepn(input logic e, input logic ld, input logic [15:0] v);
        step(e, ld, v, hc(v));
    endtask

    task automatic add(input logic e, input logic ld, input logic [15:0] v,
                       input logic c, input logic t, input logic a, input logic p);
        vecs.push_back('{en: e, ld: ld, val: v, clk: c, tck: t, ack: a, pend: p});
    endtask

    task automatic check4(input string tag, input logic c, input logic t, input logic a, input logic p);
        check({tag, " clk_out"}, clk_out, c);
        check({tag, " tick"},    tick,    t);
        check({tag, " div_ack"}, div_ack, a);
        check({tag, " pending"}, pending, p);
    endtask

`ifdef CLKGEN_DUTY_EN
    // D=8 with the given duty: high for min(duty,8) cycles, tick every 8
    task automatic duty_case(input logic [15:0] dty);
        int h;
        h = (dty > 16'd8) ? 8 : int'(dty);
        step(1'b0, 1'b1, 16'd8, dty);
        step(1'b1, 1'b0, 16'd0, 16'd0);
        check($sformatf("duty%0d ack", dty), div_ack, 1'b1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("duty%0d k%0d clk_out", dty, k), clk_out, ((k % 8) < h));
            check($sformatf("duty%0d k%0d tick", dty, k), tick, ((k % 8) == 0));
            step(1'b1, 1'b0, 16'd0, 16'd0);
        end
        step(1'b0, 1'b0, 16'd0, 16'd0);
        check($sformatf("duty%0d stop clk_out", dty), clk_out, 1'b0);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        duty_val = '0;

        // en, ld, val | clk_out, tick, div_ack, pending
        add(1, 0,  0, 1, 1, 0, 0);  // D=2: first tick one cycle after en
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 0,  0, 1, 1, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 1,  5, 1, 1, 0, 1);  // load 5 on a wrap: waits for next one
        add(1, 0,  0, 0, 0, 0, 1);
        add(1, 0,  0, 1, 1, 1, 0);  // D=5 applied, H=3
        add(1, 0,  0, 1, 0, 0, 0);  // cnt1
        add(1, 1,  3, 1, 0, 0, 1);  // load 3 at cnt=1 -> cnt2
        add(1, 0,  0, 0, 0, 0, 1);  // cnt3
        add(1, 0,  0, 0, 0, 0, 1);  // cnt4
        add(1, 0,  0, 1, 1, 1, 0);  // D=3 applied, H=2
        add(1, 0,  0, 1, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 0,  0, 1, 1, 0, 0);
        add(1, 0,  0, 1, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 1, 10, 1, 1, 0, 1);  // load 10 on a wrap
        add(1, 0,  0, 1, 0, 0, 1);
        add(1, 0,  0, 0, 0, 0, 1);
        add(1, 0,  0, 1, 1, 1, 0);  // D=10 applied, H=5
        add(1, 0,  0, 1, 0, 0, 0);  // cnt1
        add(1, 1,  7, 1, 0, 0, 1);  // load 7 -> cnt2
        add(1, 0,  0, 1, 0, 0, 1);  // cnt3
        add(1, 0,  0, 1, 0, 0, 1);  // cnt4
        add(1, 1,  4, 0, 0, 0, 1);  // load 4 overwrites -> cnt5
        add(1, 0,  0, 0, 0, 0, 1);  // cnt6
        add(1, 0,  0, 0, 0, 0, 1);  // cnt7
        add(1, 0,  0, 0, 0, 0, 1);  // cnt8
        add(1, 0,  0, 0, 0, 0, 1);  // cnt9
        add(1, 0,  0, 1, 1, 1, 0);  // only 4 applied, H=2
        add(1, 0,  0, 1, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0);
        add(1, 0,  0, 1, 1, 0, 0);  // 4-cycle period, no second ack

        repeat (2) @(posedge clk_in);
        #1;
        check4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        stepn(1'b0, 1'b0, 16'd0);
        check4("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            stepn(vecs[i].en, vecs[i].ld, vecs[i].val);
            check4($sformatf("row%0d", i), vecs[i].clk, vecs[i].tck, vecs[i].ack, vecs[i].pend);
        end

        // Load 0 while running (D=4, cnt0): stop at the boundary
        stepn(1'b1, 1'b1, 16'd0);
        check("zero pending", pending, 1'b1);
        stepn(1'b1, 1'b0, 16'd0);
        stepn(1'b1, 1'b0, 16'd0);
        stepn(1'b1, 1'b0, 16'd0);
        check4("zero applied", 1'b0, 1'b0, 1'b1, 1'b0);
        stepn(1'b1, 1'b0, 16'd0);
        check4("zero idle", 1'b0, 1'b0, 1'b0, 1'b0);
        // Load 1 while idle: applied the cycle after capture
        stepn(1'b1, 1'b1, 16'd1);
        check4("d1 captured", 1'b0, 1'b0, 1'b0, 1'b1);
        stepn(1'b1, 1'b0, 16'd0);
        check4("d1 applied", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            stepn(1'b1, 1'b0, 16'd0);
            check4($sformatf("d1 k%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // D=6, drop en at cnt=2, then restart from cnt=0
        stepn(1'b1, 1'b1, 16'd6);
        check4("d6 captured", 1'b1, 1'b1, 1'b0, 1'b1);
        stepn(1'b1, 1'b0, 16'd0);
        check4("d6 applied", 1'b1, 1'b1, 1'b1, 1'b0);
        stepn(1'b1, 1'b0, 16'd0);
        stepn(1'b1, 1'b0, 16'd0);
        check("d6 cnt2 clk_out", clk_out, 1'b1);
        stepn(1'b0, 1'b0, 16'd0);
        check("en drop clk_out", clk_out, 1'b0);
        check("en drop tick", tick, 1'b0);
        stepn(1'b0, 1'b0, 16'd0);
        check("en low clk_out", clk_out, 1'b0);
        stepn(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("restart k%0d clk_out", k), clk_out, ((k % 6) < 3));
            check($sformatf("restart k%0d tick", k), tick, ((k % 6) == 0));
            if (k < 6) stepn(1'b1, 1'b0, 16'd0);
        end

        // Async reset mid-period discards a pending divisor
        stepn(1'b1, 1'b1, 16'd3);
        check("pre-reset clk_out", clk_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        stepn(1'b1, 1'b0, 16'd0);
        check4("post-reset c0", 1'b1, 1'b1, 1'b0, 1'b0);
        stepn(1'b1, 1'b0, 16'd0);
        check4("post-reset c1", 1'b0, 1'b0, 1'b0, 1'b0);
        stepn(1'b1, 1'b0, 16'd0);
        check4("post-reset c2", 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef CLKGEN_DUTY_EN
        step(1'b0, 1'b0, 16'd0, 16'd0);
        duty_case(16'd2);
        duty_case(16'd9);
        duty_case(16'd0);
        step(1'b1, 1'b1, 16'd8, 16'd4);
        step(1'b1, 1'b0, 16'd0, 16'd0);
        step(1'b1, 1'b0, 16'd0, 16'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check4("duty async reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
